// File: rtl/matrix_feeder.sv
// rtl/matrix_feeder.sv - buffers 2*m*n host elements and replays them to matrix_mult
// after a start pulse and GAP idle cycles, then waits for done before refilling.
module matrix_feeder #(
  parameter int DW  = 8,
  parameter int m   = 8,
  parameter int n   = 8,
  parameter int GAP = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          mm_start,
  output logic [DW-1:0] mm_data,
  input  logic          mm_done,
  output logic          busy,
  output logic [15:0]   frames
);

  localparam int N  = 2 * m * n;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] LAST     = CW'(N - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [2:0] {
    S_FILL,
    S_START,
    S_GAP,
    S_STREAM,
    S_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [15:0]     frames_q, frames_d;
  logic [DW-1:0]   buf_q [N];
  logic [DW-1:0]   buf_d [N];

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    gap_cnt_d = gap_cnt_q;
    frames_d  = frames_q;
    buf_d     = buf_q;
    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          buf_d[wr_cnt_q] = in_data;
          if (wr_cnt_q == LAST) begin
            wr_cnt_d = '0;
            state_d  = S_START;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      S_START: begin
        gap_cnt_d = '0;
        state_d   = (GAP > 0) ? S_GAP : S_STREAM;
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = S_STREAM;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      S_STREAM: begin
        if (rd_cnt_q == LAST) begin
          rd_cnt_d = '0;
          state_d  = S_WAIT;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        // done is only honoured here; earlier pulses belong to no frame
        if (mm_done) begin
          frames_d = frames_q + 16'd1;
          state_d  = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FILL;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      gap_cnt_q <= '0;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      frames_q  <= frames_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset branch.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign in_ready = (state_q == S_FILL);
  assign busy     = (state_q != S_FILL);
  assign mm_start = (state_q == S_START);
  assign mm_data  = (state_q == S_STREAM) ? buf_q[rd_cnt_q] : '0;
  assign frames   = frames_q;

endmodule

// File: tb/tb_matrix_feeder.sv
// tb/tb_matrix_feeder.sv - directed self-checking bench for matrix_feeder (m=n=2, GAP=1 and GAP=0).
module tb_matrix_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mm_start;
  logic [7:0] mm_data;
  logic       mm_done;
  logic       busy;
  logic [15:0] frames;

  logic [7:0] in_data0;
  logic       in_valid0;
  logic       in_ready0;
  logic       mm_start0;
  logic [7:0] mm_data0;
  logic       mm_done0;
  logic       busy0;
  logic [15:0] frames0;

  int tests  = 0;
  int failed = 0;

  logic [7:0] va [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd3, 8'd2, 8'd1};
  logic [7:0] vb [8] = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd13};
  logic [7:0] vc [8] = '{8'd9, 8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd13};

  matrix_feeder #(.DW(8), .m(2), .n(2), .GAP(1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mm_start(mm_start), .mm_data(mm_data),
    .mm_done(mm_done), .busy(busy), .frames(frames)
  );

  matrix_feeder #(.DW(8), .m(2), .n(2), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .mm_start(mm_start0), .mm_data(mm_data0),
    .mm_done(mm_done0), .busy(busy0), .frames(frames0)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives elements e[s..e_end-1]; returns in cycle L+1 when the last is accepted.
  task automatic load(input logic [7:0] e [8], input int s, input int e_end, input bit gapped);
    for (int i = s; i < e_end; i++) begin
      if (gapped && i > s) begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
        step();
      end
      chk("in_ready_fill", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = e[i];
      step();
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // Entered in cycle L+1; checks start, gap cycle and nel streamed elements.
  task automatic stream_check(input logic [7:0] e [8], input int nel, input bit early);
    mm_done = early;
    chk("mm_start_pulse", {31'd0, mm_start}, 32'd1);
    chk("in_ready_start", {31'd0, in_ready}, 32'd0);
    chk("busy_start", {31'd0, busy}, 32'd1);
    chk("mm_data_start", {24'd0, mm_data}, 32'd0);
    step();
    chk("mm_start_gap", {31'd0, mm_start}, 32'd0);
    chk("mm_data_gap", {24'd0, mm_data}, 32'd0);
    for (int k = 0; k < nel; k++) begin
      step();
      chk($sformatf("mm_data_el%0d", k), {24'd0, mm_data}, {24'd0, e[k]});
    end
    mm_done = 1'b0;
    if (nel == 8) begin
      step();
      chk("mm_data_after", {24'd0, mm_data}, 32'd0);
      chk("in_ready_wait", {31'd0, in_ready}, 32'd0);
    end
  endtask

  task automatic done_pulse(input logic [15:0] exp_frames);
    mm_done = 1'b1;
    chk("in_ready_done_cycle", {31'd0, in_ready}, 32'd0);
    step();
    mm_done = 1'b0;
    chk("in_ready_after_done", {31'd0, in_ready}, 32'd1);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("frames", {16'd0, frames}, {16'd0, exp_frames});
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mm_data", {24'd0, mm_data}, 32'd0);
    chk("rst_mm_start", {31'd0, mm_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frames", {16'd0, frames}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    mm_done   = 1'b0;
    in_data0  = 8'h00;
    in_valid0 = 1'b0;
    mm_done0  = 1'b0;
    step();
    step();
    reset_pulse();

    // back-to-back load
    load(va, 0, 8, 1'b0);
    stream_check(va, 8, 1'b0);
    step();
    chk("in_ready_hold", {31'd0, in_ready}, 32'd0);
    done_pulse(16'd1);

    // gapped input
    load(va, 0, 8, 1'b1);
    stream_check(va, 8, 1'b0);
    done_pulse(16'd2);

    // back-pressure during WAIT_DONE
    load(vb, 0, 8, 1'b0);
    stream_check(vb, 8, 1'b0);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 8'd9;
      chk("no_handshake_wait", {31'd0, in_ready}, 32'd0);
      step();
    end
    done_pulse(16'd3);
    step();
    load(vb, 1, 8, 1'b0);
    stream_check(vc, 8, 1'b0);
    done_pulse(16'd4);

    // early done ignored
    load(va, 0, 8, 1'b0);
    stream_check(va, 8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("early_done_in_ready", {31'd0, in_ready}, 32'd0);
      chk("early_done_frames", {16'd0, frames}, 32'd4);
    end
    done_pulse(16'd5);

    // reset mid-fill
    load(va, 0, 5, 1'b0);
    reset_pulse();
    load(vb, 0, 8, 1'b0);
    stream_check(vb, 8, 1'b0);
    done_pulse(16'd1);

    // reset mid-stream after the 3rd element
    load(va, 0, 8, 1'b0);
    stream_check(va, 3, 1'b0);
    reset_pulse();
    load(vb, 0, 8, 1'b0);
    stream_check(vb, 8, 1'b0);
    done_pulse(16'd1);

    // GAP=0 instance
    for (int i = 0; i < 8; i++) begin
      chk("g0_in_ready", {31'd0, in_ready0}, 32'd1);
      in_valid0 = 1'b1;
      in_data0  = va[i];
      step();
    end
    in_valid0 = 1'b0;
    chk("g0_mm_start", {31'd0, mm_start0}, 32'd1);
    chk("g0_mm_data_start", {24'd0, mm_data0}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("g0_el%0d", k), {24'd0, mm_data0}, {24'd0, va[k]});
    end
    step();
    chk("g0_mm_data_after", {24'd0, mm_data0}, 32'd0);
    mm_done0 = 1'b1;
    step();
    mm_done0 = 1'b0;
    chk("g0_frames", {16'd0, frames0}, 32'd1);
    chk("g0_in_ready_after", {31'd0, in_ready0}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
